// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between valid/ready pipeline stages.
// in_ready is derived only from registered occupancy, so it breaks the ready path.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   stall_d;
    logic               in_fire;
    logic               out_fire;
    logic               stall_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stall_c  = out_valid & ~out_ready;
    assign stall_d  = stall_c ? sat_inc(stall_q) : stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            // The stall counter keeps counting through a flush.
            stall_q <= stall_d;
            if (flush) begin
                state_q <= EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_q <= ONE;
                            main_q  <= in_data;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_q <= in_data;
                        end else if (in_fire) begin
                            state_q <= FULL;
                            skid_q  <= in_data;
                        end else if (out_fire) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            state_q <= ONE;
                            main_q  <= skid_q;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized and directed bench for pipe_skid_stage, checked against a queue-based model.
module tb_pipe_skid_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int MAXC   = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] mq[$];
    int                m_stall = 0;
    int                delivered = 0;
    int                accepted  = 0;

    pipe_skid_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; the model is a FIFO of at most two words.
    task automatic tick();
        bit stall_c, ifire, ofire;
        logic [DATA_W-1:0] d;
        stall_c = (mq.size() != 0) && !out_ready;
        ifire   = in_valid && (mq.size() < 2);
        ofire   = (mq.size() != 0) && out_ready;
        d       = in_data;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (stall_c && m_stall < MAXC) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (ofire) begin
                    void'(mq.pop_front());
                    delivered++;
                end
                if (ifire) begin
                    mq.push_back(d);
                    accepted++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (stall_cnt !== '0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] words[3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = words[i];
            tick();
            total++; if (out_data !== words[i]) begin bad++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, out_data, words[i]); end
            total++; if (out_valid !== 1'b1 || occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d/%0b exp=1/1", i, occupancy, out_valid); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%0b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bp_occ_full got=%0d exp=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        total++; if (out_data !== 32'hA) begin bad++; $display("FAIL bp_head got=%0h exp=a", out_data); end
        total++; if (stall_cnt !== CNT_W'(m_stall)) begin bad++; $display("FAIL bp_stall got=%0d exp=%0d", stall_cnt, m_stall); end
        tick();
        total++; if (out_data !== 32'hA || out_valid !== 1'b1 || occupancy !== 2'd2) begin bad++; $display("FAIL bp_hold got=%0h exp=a", out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 32'hB || occupancy !== 2'd1) begin bad++; $display("FAIL bp_second got=%0h/%0d exp=b/1", out_data, occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_again got=%0b exp=1", in_ready); end
        tick();
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] s_before;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        s_before = stall_cnt;
        flush = 1'b1; out_ready = 1'b1; in_data = 32'hC;
        tick();
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d/%0b exp=0/0", occupancy, out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL flush_data got=%0h exp=0", out_data); end
        total++; if (stall_cnt !== s_before) begin bad++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt, s_before); end
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hD0 + DATA_W'(i);
            tick();
            total++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_hold[%0d] got=%0d/%0b exp=0/1", i, occupancy, in_ready); end
        end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_after got=%0d exp=0", occupancy); end
    endtask

    task automatic test_stall_sat();
        int exp_s;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_s = (i < MAXC) ? i : MAXC;
            total++; if (stall_cnt !== CNT_W'(exp_s)) begin bad++; $display("FAIL stall_sat[%0d] got=%0d exp=%0d", i, stall_cnt, exp_s); end
        end
        total++; if (out_data !== 32'h5 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0h exp=5", out_data); end
        out_ready = 1'b1;
        tick();
        total++; if (stall_cnt !== CNT_W'(MAXC) || occupancy !== 2'd0) begin bad++; $display("FAIL stall_final got=%0d/%0d exp=15/0", stall_cnt, occupancy); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        reset = 1'b1; in_data = 32'hDEAD;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_occ got=%0d exp=0", occupancy); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rstfull_data got=%0h exp=0", out_data); end
        total++; if (stall_cnt !== '0) begin bad++; $display("FAIL rstfull_stall got=%0d exp=0", stall_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_in_ready got=%0b exp=1", in_ready); end
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rstfull_nocapture got=%0d exp=0", occupancy); end
    endtask

    task automatic test_random();
        int errs = 0;
        int v_bias, r_bias;
        do_reset();
        accepted = 0; delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                v_bias = $urandom_range(10, 95);
                r_bias = $urandom_range(10, 95);
            end
            in_valid  = ($urandom_range(0, 99) < v_bias);
            out_ready = ($urandom_range(0, 99) < r_bias);
            flush     = ($urandom_range(0, 199) == 0);
            in_data   = {$urandom_range(0, 65535), 16'(c)};
            tick();
            if (errs < 10) begin
                total++;
                if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() != 0)) begin
                    bad++; errs++; $display("FAIL rand_occ[%0d] got=%0d exp=%0d", c, occupancy, mq.size());
                end
                total++;
                if (in_ready !== (mq.size() < 2)) begin
                    bad++; errs++; $display("FAIL rand_in_ready[%0d] got=%0b exp=%0b", c, in_ready, mq.size() < 2);
                end
                total++;
                if (stall_cnt !== CNT_W'(m_stall)) begin
                    bad++; errs++; $display("FAIL rand_stall[%0d] got=%0d exp=%0d", c, stall_cnt, m_stall);
                end
                if (mq.size() != 0) begin
                    total++;
                    if (out_data !== mq[0]) begin
                        bad++; errs++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", c, out_data, mq[0]);
                    end
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (occupancy !== 2'd0 || accepted < 1000) begin
            bad++; $display("FAIL rand_drain got=%0d/%0d exp=0/>=1000", occupancy, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_sat();
        test_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
